fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of the instruction decoder. Owns the PC and
//  issues word reads to a 1-cycle-latency synchronous IMEM. Buffers returned words with
//  their PC in a small FIFO and presents them to decode over a valid/ready handshake.
//  Accepts redirects (branch/jump/JALR) from later stages and squashes wrong-path fetches.
// PARAMETERS
//  RESET_PC    32'h2000_0000  PC fetched first after reset
//  FIFO_DEPTH  2              output buffer entries (>=2; 2 sustains 1 instr/cycle)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   synchronous reset, active-high
//  imem_en         out  1   read request this cycle
//  imem_addr       out  32  byte address of request, bits[1:0]=0
//  imem_dout       in   32  read data, valid the cycle after imem_en
//  redirect_valid  in   1   load new PC, flush the stage
//  redirect_pc     in   32  redirect target; bits[1:0] ignored (forced 0)
//  out_valid       out  1   out_instr/out_pc valid
//  out_ready       in   1   decode accepts this cycle
//  out_instr       out  32  instruction word
//  out_pc          out  32  PC of out_instr
//  out_pred_taken  out  1   instr was a predicted-taken JAL (0 without FETCH_JAL_PREDICT_EN)
// BEHAVIOUR
//  - Reset: pc_q=RESET_PC, FIFO empty, in-flight cleared; imem_en=0, out_valid=0,
//    out_pred_taken=0 while rst=1. First request (addr RESET_PC) in the first cycle with rst=0.
//  - Issue: imem_en = !rst && !redirect_valid && (occ + inflight - pop) < FIFO_DEPTH, where
//    pop = out_valid&out_ready (combinational from out_ready). imem_addr=pc_q; on issue pc_q+=4.
//  - Capture: the cycle after an issue, imem_dout + request PC pushed into FIFO unless killed.
//  - Latency: request in cycle t -> out_valid in t+2 (FIFO registered, no fall-through).
//  - Throughput: 1 instr/cycle while out_ready=1 continuously.
//  - Handshake: out_* stable while out_valid=1 and out_ready=0; transfer on valid&ready.
//  - Redirect (highest priority): pc_q<=redirect_pc&~3; FIFO cleared; response arriving
//    next cycle discarded; no issue in the redirect cycle; new-target request next cycle,
//    out_valid for it 2 cycles later. A transfer completing in the redirect cycle counts
//    as done. Back-to-back redirects: last one wins.
//  - FIFO full with out_ready=0: no issue, pc_q holds, nothing lost (credit check guarantees
//    a slot for every in-flight response).
//  - PC wrap 32'hFFFF_FFFC+4 -> 0, no flag.
//  - rst mid-operation: in-flight response discarded, state as reset.
// CONFIGURATION
//  FETCH_JAL_PREDICT_EN defined: captured word with opcode==OPC_JAL (not killed) is tagged
//   out_pred_taken=1; in the capture cycle issue suppressed, pc_q<=req_pc+sext(J-imm).
//   Target request next cycle. External redirect in the same cycle overrides prediction.
//  Undefined: no predecode; out_pred_taken tied 0; sequential fetch until redirect.
// STRUCTURE
//  - Shared header: Opcode.vh (OPC_JAL), PC_RESET constant, INSTR_NOP (32'h0000_0013).
//  - Sub-module fetch_fifo: FIFO_DEPTH x {pc,instr,pred} with push/pop/flush, occ count.
//  - Top: PC register, in-flight/kill bit, request-PC register, credit logic, J-imm predecode.
// TESTING
//  - Reset release, out_ready=1: imem_addr 2000_0000,_0004,_0008 on cycles 0,1,2;
//    out_pc 2000_0000 at cycle 2, then +4 every cycle.
//  - out_ready=0 from cycle 2 for 5 cycles: imem_en drops after 2 entries buffered;
//    on release out_pc continues _0000,_0004,_0008 with no gap or duplicate.
//  - redirect_valid, redirect_pc=32'h0000_1002 while FIFO holds 2: next out_pc=0000_1000,
//    no older PC ever appears after the redirect cycle.
//  - Redirect on same cycle as pop: popped entry delivered once; remaining entry flushed.
//  - Macro on: word 32'h0080_006F (jal x0,+8) at PC 2000_0000 -> out_pred_taken=1,
//    next out_pc=2000_0008; macro off: out_pred_taken=0, next out_pc=2000_0004.
//  - rst asserted with FIFO full: out_valid=0 next cycle, refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: opcode, reset PC, NOP word, FIFO entry layout and
// J-type immediate helpers used by the optional JAL predecode (FETCH_JAL_PREDICT_EN).
package fetch_pkg;

  localparam logic [6:0]  OPC_JAL   = 7'b110_1111;
  localparam logic [31:0] PC_RESET  = 32'h2000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } fetch_entry_t;

  function automatic logic is_jal(input logic [31:0] word);
    return word[6:0] == OPC_JAL;
  endfunction

  // Sign-extended J-type offset: imm[20|10:1|11|19:12] scattered over word[31:12].
  function automatic logic [31:0] jal_imm(input logic [31:0] word);
    return {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered output buffer for fetched words: DEPTH x {pc, instr, pred}, push/pop/flush.
// The head entry is read straight from storage, so a push is never visible the same cycle.
import fetch_pkg::*;

module fetch_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_entry_t                 push_data_i,
  input  logic                         pop_i,
  output fetch_entry_t                 head_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (occ_q != '0);
  // A full buffer only accepts a push when its head leaves in the same cycle.
  assign do_push = push_i && ((occ_q != OW'(DEPTH)) || do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    occ_d = occ_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      occ_d = '0;
    end else begin
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_pop)  rd_d = ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '{pc: 32'h0, instr: INSTR_NOP, pred: 1'b0};
      end
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      occ_q <= occ_d;
      if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign valid_o = (occ_q != '0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle IMEM, buffers responses
// for decode and honours redirects. Macro FETCH_JAL_PREDICT_EN enables JAL predecode.
import fetch_pkg::*;

module fetch_stage #(
  parameter logic [31:0] RESET_PC   = PC_RESET,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_pred_taken
);

  // Handshake: an entry transfers to decode on any cycle with out_valid && out_ready;
  // while out_valid is high and out_ready low, out_pc/out_instr/out_pred_taken hold.

  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW = OW + 1;

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         inflight_q, inflight_d;
  logic [OW-1:0] occ;
  logic [CW-1:0] used;
  logic         fifo_valid;
  logic         pop;
  logic         push;
  logic         credit_ok;
  logic         jal_hit;
  logic         issue;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  assign out_valid = fifo_valid && !rst;
  assign pop       = out_valid && out_ready;

  // A response arriving in a redirect (or reset) cycle belongs to the wrong path.
  assign push = inflight_q && !redirect_valid && !rst;

  // Every outstanding request already owns a buffer slot, so a full buffer never drops data.
  assign used      = CW'(occ) + CW'(inflight_q);
  assign credit_ok = used < (CW'(FIFO_DEPTH) + CW'(pop));

`ifdef FETCH_JAL_PREDICT_EN
  assign jal_hit = push && is_jal(imem_dout);
`else
  assign jal_hit = 1'b0;
`endif

  // The capture cycle of a predicted JAL re-steers instead of fetching the fall-through.
  assign issue = !rst && !redirect_valid && !jal_hit && credit_ok;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (issue) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + 32'd4;
    end
    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'd3;
    end else if (jal_hit) begin
      pc_d = req_pc_q + jal_imm(imem_dout);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign imem_en   = issue;
  assign imem_addr = pc_q;

  assign push_entry = '{pc: req_pc_q, instr: imem_dout, pred: jal_hit};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (fifo_valid),
    .occ_o       (occ)
  );

  assign out_pc         = head.pc;
  assign out_instr      = head.instr;
  assign out_pred_taken = head.pred && out_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: IMEM model, program-order reference model feeding an expected
// queue, a monitor checking every decode transfer, directed timing checks, random phase.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h2000_0000;
`ifdef FETCH_JAL_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_pred_taken;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pred_taken (out_pred_taken)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int delivered = 0;

  logic [31:0] mem_ovr [logic [31:0]];
  bit          jal_zone = 1'b0;
  logic [64:0] exp_q [$];
  logic [31:0] exp_next = RST_PC;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program image: hashed words, optional JAL sprinkles, explicit overrides.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    if (jal_zone && a[6:2] == 5'h0B) return 32'h0100_006F;
    if (jal_zone && a[6:2] == 5'h1D) return 32'hFF9F_F06F;
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (w[6:0] == 7'h6F) w[0] = 1'b0;
    return w;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w);
    logic signed [20:0] off;
    if (PRED && w[6:0] == 7'h6F) begin
      off = {w[31], w[19:12], w[20], w[30:21], 1'b0};
      return pc + 32'(int'(off));
    end
    return pc + 32'd4;
  endfunction

  task automatic top_up();
    logic [31:0] w;
    while (exp_q.size() < 24) begin
      w = mem_word(exp_next);
      exp_q.push_back({exp_next, w, PRED && (w[6:0] == 7'h6F)});
      exp_next = model_next(exp_next, w);
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    exp_next = pc;
    top_up();
  endtask

  // IMEM: synchronous read, 1-cycle latency; garbage when not enabled.
  always @(posedge clk) begin
    imem_dout <= imem_en ? mem_word(imem_addr) : $urandom();
  end

  // Monitor: every transfer is popped against the expected program-order stream.
  logic        p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1, p_redir = 1'b0;
  logic [31:0] p_pc = 32'h0, p_instr = 32'h0;
  logic [64:0] e;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
      chk("rst_pred", {31'b0, out_pred_taken}, 32'd0);
      restart(RST_PC);
    end else begin
      if (p_valid && !p_ready && !p_rst && !p_redir) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_pc", out_pc, p_pc);
        chk("hold_instr", out_instr, p_instr);
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk("xfer_pc", out_pc, e[64:33]);
        chk("xfer_instr", out_instr, e[32:1]);
        chk("xfer_pred", {31'b0, out_pred_taken}, {31'b0, e[0]});
        delivered++;
        top_up();
      end
      if (redirect_valid) restart(redirect_pc & ~32'd3);
    end
    p_valid = out_valid; p_ready = out_ready; p_rst = rst; p_redir = redirect_valid;
    p_pc = out_pc; p_instr = out_instr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit zone, input bit jal_at_reset);
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    jal_zone = zone;
    mem_ovr.delete();
    if (jal_at_reset) mem_ovr[RST_PC] = 32'h0080_006F;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for the next transfer and checks its PC; returns after that cycle.
  task automatic wait_xfer(input string name, input logic [31:0] exp_pc, output logic got_pred);
    int n = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_seen"}, {31'b0, out_valid && out_ready}, 32'd1);
    chk(name, out_pc, exp_pc);
    got_pred = out_pred_taken;
    tick();
  endtask

  task automatic at_neg_chk(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    chk(name, act_sel, exp);
  endtask

  logic gp;
  int   d0;

  initial begin
    // Reset release with continuous out_ready: issue timing, latency and throughput.
    do_reset(1'b0, 1'b0);
    out_ready = 1'b1;
    d0 = delivered;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c < 3) begin
        chk("t1_imem_en", {31'b0, imem_en}, 32'd1);
        chk("t1_imem_addr", imem_addr, RST_PC + 32'(4 * c));
      end
      if (c < 2) chk("t1_no_early_valid", {31'b0, out_valid}, 32'd0);
      if (c >= 2) chk("t1_out_pc", out_pc, RST_PC + 32'(4 * (c - 2)));
      tick();
    end
    chk("t1_throughput", 32'(delivered - d0), 32'd18);

    // Stall from cycle 2 for 5 cycles: issue stops, head holds, resume with no gap.
    do_reset(1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    for (int c = 2; c < 7; c++) begin
      @(negedge clk);
      chk("t2_stall_imem_en", {31'b0, imem_en}, 32'd0);
      chk("t2_stall_head", out_pc, RST_PC);
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t2_resume_pc", out_pc, RST_PC + 32'(4 * c));
      tick();
    end

    // Redirect while the buffer holds two entries and decode is stalled.
    do_reset(1'b0, 1'b0);
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1002;
    @(negedge clk);
    chk("t3_no_issue_on_redirect", {31'b0, imem_en}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_target_req_en", {31'b0, imem_en}, 32'd1);
    chk("t3_target_req_addr", imem_addr, 32'h0000_1000);
    chk("t3_flushed", {31'b0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("t3_flushed2", {31'b0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("t3_target_valid", {31'b0, out_valid}, 32'd1);
    chk("t3_target_pc", out_pc, 32'h0000_1000);
    tick();

    // Redirect in the same cycle as a pop: the popped entry counts, the other is dropped.
    do_reset(1'b0, 1'b0);
    repeat (3) tick();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3000;
    d0 = delivered;
    tick();
    redirect_valid = 1'b0;
    chk("t4_pop_counted", 32'(delivered - d0), 32'd1);
    @(negedge clk);
    chk("t4_rest_flushed", {31'b0, out_valid}, 32'd0);
    tick();
    wait_xfer("t4_target_pc", 32'h0000_3000, gp);

    // JAL at the reset PC: predicted-taken tag and steered next PC only with predecode.
    do_reset(1'b0, 1'b1);
    out_ready = 1'b1;
    wait_xfer("t5_jal_pc", RST_PC, gp);
    chk("t5_jal_pred", {31'b0, gp}, {31'b0, PRED});
    wait_xfer("t5_next_pc", PRED ? RST_PC + 32'd8 : RST_PC + 32'd4, gp);

    // PC wrap through the top of the address space, unaligned redirect target.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF9;
    tick();
    redirect_valid = 1'b0;
    wait_xfer("t6_wrap0", 32'hFFFF_FFF8, gp);
    wait_xfer("t6_wrap1", 32'hFFFF_FFFC, gp);
    wait_xfer("t6_wrap2", 32'h0000_0000, gp);

    // Reset with the buffer full: outputs drop at once, refetch from the reset PC.
    do_reset(1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t7_refetch_addr", imem_addr, RST_PC);
    chk("t7_refetch_en", {31'b0, imem_en}, 32'd1);
    tick();
    tick();
    @(negedge clk);
    chk("t7_refetch_pc", out_pc, RST_PC);
    tick();

    // Random traffic: back-pressure, redirects (incl. near wrap), JALs, sporadic reset.
    do_reset(1'b1, 1'b0);
    d0 = delivered;
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 2))
        0:       redirect_pc = RST_PC + 32'($urandom_range(0, 255));
        1:       redirect_pc = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
        default: redirect_pc = $urandom();
      endcase
      rst = ($urandom_range(0, 999) < 3);
      tick();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("t8_random_progress", {31'b0, (delivered - d0) > 1000}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
